// File: rtl/npu_dot_pkg.sv
// Shared widths and scheduler state encoding for the dot-product job scheduler.
package npu_dot_pkg;
  localparam int VEC_LEN = 16;
  localparam int ELEM_W  = 8;
  localparam int RES_W   = 16;
  localparam int VEC_W   = VEC_LEN * ELEM_W;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    START,
    BUSY,
    RESP
  } sched_state_t;
endpackage

// File: rtl/dot_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // one extra bit so ptr + i cannot overflow before the wrap
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                      = 1'b1;
        idx                      = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dot_job_sched.sv
// Round-robin job scheduler sharing one matrix_dot engine among N_REQ requesters,
// with a per-job engine reset pulse and a BUSY watchdog.
module dot_job_sched
  import npu_dot_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 8191,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*VEC_W-1:0]           req_a,
  input  logic [N_REQ*VEC_W-1:0]           req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [RES_W-1:0]                 rsp_data,
  output logic                             rsp_timeout,
  output logic                             eng_rst_n,
  output logic                             eng_start,
  output logic [VEC_LEN-1:0][ELEM_W-1:0]   eng_a,
  output logic [VEC_LEN-1:0][ELEM_W-1:0]   eng_b,
  input  logic [RES_W-1:0]                 eng_c,
  input  logic                             eng_done
);
  sched_state_t     state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [WD_W-1:0]  wd_reg;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  logic [VEC_W-1:0] a_slice [N_REQ];
  logic [VEC_W-1:0] b_slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[gi*VEC_W +: VEC_W];
    assign b_slice[gi] = req_b[gi*VEC_W +: VEC_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // The grant must be visible in the same IDLE cycle the request is seen.
  assign req_ready = (state_reg == IDLE) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      wd_reg      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      eng_rst_n   <= 1'b0;
      eng_start   <= 1'b0;
      eng_a       <= '0;
      eng_b       <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          eng_rst_n <= 1'b1;
          if (gnt_any) begin
            eng_a     <= a_slice[gnt_idx];
            eng_b     <= b_slice[gnt_idx];
            rsp_id    <= gnt_idx;
            ptr_reg   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            eng_rst_n <= 1'b0;
            state_reg <= CLR;
          end
        end
        CLR: begin
          // engine done is sticky, so the reset pulse precedes every start
          eng_rst_n <= 1'b1;
          eng_start <= 1'b1;
          state_reg <= START;
        end
        START: begin
          eng_start <= 1'b0;
          wd_reg    <= '0;
          state_reg <= BUSY;
        end
        BUSY: begin
          wd_reg <= wd_reg + 1'b1;
          if (eng_done) begin
            rsp_data    <= eng_c;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state_reg   <= RESP;
          end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_job_sched.sv
// Directed bench for dot_job_sched with a behavioural engine stub and an in-order
// scoreboard of expected responses.
module tb_dot_job_sched;
  logic               clk;
  logic               rst;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [511:0]       req_a;
  logic [511:0]       req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [15:0]        rsp_data;
  logic               rsp_timeout;
  logic               eng_rst_n;
  logic               eng_start;
  logic [15:0][7:0]   eng_a;
  logic [15:0][7:0]   eng_b;
  logic [15:0]        eng_c;
  logic               eng_done;

  dot_job_sched #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .eng_rst_n   (eng_rst_n),
    .eng_start   (eng_start),
    .eng_a       (eng_a),
    .eng_b       (eng_b),
    .eng_c       (eng_c),
    .eng_done    (eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dot16(input logic [15:0][7:0] a, input logic [15:0][7:0] b);
    logic [15:0] s;
    s = '0;
    for (int j = 0; j < 16; j++) s = s + a[j] * b[j];
    return s;
  endfunction

  // Engine stub: done appears eng_lat cycles into BUSY, sticky until eng_rst_n low.
  int          eng_lat = 20;
  bit          eng_hang = 1'b0;
  int          stub_cnt;
  logic        stub_busy;
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      eng_done  <= 1'b0;
      eng_c     <= '0;
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (eng_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 0;
    end else if (stub_busy && !eng_hang) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == eng_lat - 1) begin
        eng_done  <= 1'b1;
        eng_c     <= dot16(eng_a, eng_b);
        stub_busy <= 1'b0;
      end
    end
  end

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  typedef struct {
    int          id;
    logic [15:0] data;
    bit          to;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int grant_cnt, rstlow_cnt, start_cnt, start_cyc, rsp_cyc;
  bit rsp_seen = 1'b0;
  logic [3:0] gseen;
  logic [15:0][7:0] va, vb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [127:0] a, input logic [127:0] b,
                         input bit push, input bit to);
    req_a[r*128 +: 128] = a;
    req_b[r*128 +: 128] = b;
    req_valid[r] = 1'b1;
    if (push) sb.push_back('{id: r, data: (to ? 16'd0 : dot16(a, b)), to: to});
  endtask

  task automatic observe();
    @(negedge clk);
    gseen = req_valid & req_ready;
    if (req_ready != 4'b0) begin
      grant_cnt++;
      chk("grant_onehot_valid", {31'b0, $onehot(req_ready) && ((req_ready & ~req_valid) == 4'b0)}, 1);
    end
    if (!eng_rst_n) rstlow_cnt++;
    if (eng_start) begin
      start_cnt++;
      start_cyc = cyc_no;
    end
    if (rsp_valid && !rsp_seen) rsp_cyc = cyc_no;
    rsp_seen = rsp_valid;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gseen;
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", {31'b0, sb.size() != 0}, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_timeout", rsp_timeout, e.to);
    end
  endtask

  task automatic service(input int n, input int limit);
    int got = 0;
    for (int c = 0; c < limit && got < n; c++) begin
      observe();
      if (rsp_valid && rsp_ready) begin
        pop_check();
        got++;
      end
      advance();
    end
    chk("service_done", got, n);
  endtask

  task automatic wait_cond(input int sel, input int limit, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < limit && !hit; c++) begin
      observe();
      hit = (sel == 0) ? rsp_valid : eng_start;
      if (!hit) advance();
    end
    if (sel == 0) chk("wait_rsp", hit, 1);
    else          chk("wait_start", hit, 1);
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst_n_low", eng_rst_n, 0);
    chk("rst_eng_ab_zero", {31'b0, (eng_a === '0) && (eng_b === '0)}, 1);
    @(negedge clk);
    chk("rst_eng_rst_n_high", eng_rst_n, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_seen = 1'b0;
    check_reset_vals();
  endtask

  initial begin
    bit hit;
    bit bad;
    logic [1:0]  h_id;
    logic [15:0] h_data;
    logic        h_to;

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    do_reset(3);

    // 1: single job, a[j]=j, b[j]=1 -> 120
    for (int j = 0; j < 16; j++) begin va[j] = 8'(j); vb[j] = 8'd1; end
    rstlow_cnt = 0; start_cnt = 0;
    set_req(0, va, vb, 1'b1, 1'b0);
    service(1, 200);
    chk("t1_eng_rst_pulse", rstlow_cnt, 1);
    chk("t1_start_pulse", start_cnt, 1);
    chk("t1_latency", rsp_cyc - start_cyc, eng_lat + 2);

    // 2: all four requesters at once from pointer 0 -> ids 0,1,2,3
    do_reset(1);
    grant_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 16; j++) begin va[j] = 8'd1; vb[j] = 8'(r + 1); end
      set_req(r, va, vb, 1'b1, 1'b0);
    end
    service(4, 400);
    chk("t2_grant_cycles", grant_cnt, 4);

    // 3: full-scale operands wrap mod 2^16 (golden 57360)
    for (int j = 0; j < 16; j++) begin va[j] = 8'd255; vb[j] = 8'd255; end
    set_req(2, va, vb, 1'b1, 1'b0);
    service(1, 200);

    // pointer now 3 with req3 idle: wrap to 0, then 1
    set_req(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    set_req(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    service(2, 300);

    // done arriving on the last watchdog cycle wins over the timeout
    eng_lat = 63;
    set_req(3, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    service(1, 200);
    chk("done_wins_latency", rsp_cyc - start_cyc, 65);

    // done one cycle too late loses
    eng_lat = 64;
    set_req(3, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    service(1, 200);
    chk("late_done_latency", rsp_cyc - start_cyc, 65);

    // 5: engine never finishes -> timeout after 64 BUSY cycles
    eng_lat = 20;
    eng_hang = 1'b1;
    set_req(2, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    service(1, 200);
    chk("t5_timeout_latency", rsp_cyc - start_cyc, 65);
    eng_hang = 1'b0;

    // 4: consumer stalls 20 cycles; outputs hold, no grants; req3 pulses and withdraws
    do_reset(1);
    rsp_ready = 1'b0;
    set_req(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    set_req(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    wait_cond(0, 200, hit);
    h_id = rsp_id; h_data = rsp_data; h_to = rsp_timeout;
    advance();
    for (int i = 0; i < 20; i++) begin
      if (i == 3) req_valid[3] = 1'b1;
      if (i == 8) req_valid[3] = 1'b0;
      observe();
      chk("t4_hold_stable", {rsp_valid, rsp_id, rsp_data, rsp_timeout, req_ready},
          {1'b1, h_id, h_data, h_to, 4'b0000});
      advance();
    end
    rsp_ready = 1'b1;
    observe();
    chk("t4_release_valid", rsp_valid, 1);
    pop_check();
    advance();
    observe();
    chk("t4_grant_after_release", req_ready, 4'b0010);
    advance();
    service(1, 200);

    // 6: reset during BUSY discards the job; req1 then completes normally
    eng_lat = 40;
    set_req(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    wait_cond(1, 50, hit);
    advance();
    repeat (5) begin observe(); advance(); end
    do_reset(1);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      observe();
      bad = bad | rsp_valid;
      advance();
    end
    chk("t6_no_rsp_after_abort", bad, 0);
    eng_lat = 20;
    for (int j = 0; j < 16; j++) begin va[j] = 8'(3 * j + 1); vb[j] = 8'(200 - j); end
    set_req(1, va, vb, 1'b1, 1'b0);
    service(1, 200);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
